// File: rtl/ysyx_23060077_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, bit positions,
// Zicsr operation encodings and trap cause codes.
package ysyx_23060077_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIP_MTIP       = 7;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  // Addresses 0xC00-0xFFF are read-only by the privileged address map.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/ysyx_23060077_csr_counter64.sv
// 64-bit free-running counter with per-half CSR writes; a write to either half
// suppresses the increment for that edge.
module ysyx_23060077_csr_counter64 #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc_i,
  input  logic            wr_lo_i,
  input  logic            wr_hi_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rd_lo_o,
  output logic [XLEN-1:0] rd_hi_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 64'(inc_i);
    if (wr_lo_i || wr_hi_i) cnt_d = cnt_q;
    if (XLEN == 64) begin
      if (wr_lo_i) cnt_d = 64'(wdata_i);
    end else begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i[31:0];
      if (wr_hi_i) cnt_d[63:32] = wdata_i[31:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rd_lo_o = cnt_q[XLEN-1:0];
  assign rd_hi_o = cnt_q[63:64-XLEN];

endmodule

// File: rtl/ysyx_23060077_csr_file.sv
// Machine-mode CSR file: Zicsr access, trap/mret state stacking, timer
// interrupt pending, 64-bit cycle/instret counters and redirect PC.
module ysyx_23060077_csr_file
  import ysyx_23060077_csr_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter int          HAS_COUNTERS  = 1,
  parameter logic [31:0] MVENDORID_VAL = 32'h79737978,
  parameter logic [31:0] MARCHID_VAL   = 32'h015FDE6D
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic            trap_irq,
  input  logic [3:0]      trap_code,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            instret_inc,
  input  logic            timer_irq,
  output logic            irq_pending,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] csr_mstatus
);

  localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

  logic            mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;

  logic [XLEN-1:0] rdata, wval, mstatus_val, vec_base, vec_off;
  logic [XLEN-1:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
  logic            addr_ok, wr_effect, illegal, csr_we;
  csr_op_e         op;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_val[MSTATUS_MPIE] = mpie_q;
    mstatus_val[MSTATUS_MIE]  = mie_q;
  end

  always_comb begin
    rdata   = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   rdata = mstatus_val;
      CSR_MIE:       rdata[MIE_MTIE] = mtie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MIP:       rdata[MIP_MTIP] = timer_irq;
      CSR_MVENDORID: rdata = XLEN'(MVENDORID_VAL);
      CSR_MARCHID:   rdata = XLEN'(MARCHID_VAL);
      CSR_MCYCLE:    if (HAS_COUNTERS != 0) rdata = cyc_lo; else addr_ok = 1'b0;
      CSR_MINSTRET:  if (HAS_COUNTERS != 0) rdata = ins_lo; else addr_ok = 1'b0;
      CSR_MCYCLEH:   if (HAS_COUNTERS != 0 && XLEN == 32) rdata = cyc_hi; else addr_ok = 1'b0;
      CSR_MINSTRETH: if (HAS_COUNTERS != 0 && XLEN == 32) rdata = ins_hi; else addr_ok = 1'b0;
      default:       addr_ok = 1'b0;
    endcase
  end

  // RS/RC with a zero mask is a pure read, so it may target read-only space.
  assign wr_effect   = (op == CSR_OP_RW) ||
                       ((op == CSR_OP_RS || op == CSR_OP_RC) && (|csr_wdata));
  assign illegal     = !addr_ok || (csr_is_ro(csr_addr) && wr_effect);
  assign csr_illegal = illegal;
  assign csr_rdata   = rdata;
  assign csr_we      = csr_valid && !illegal && (op != CSR_OP_NONE) &&
                       !trap_valid && !mret_valid;

  always_comb begin
    case (op)
      CSR_OP_RW: wval = csr_wdata;
      CSR_OP_RS: wval = rdata | csr_wdata;
      CSR_OP_RC: wval = rdata & ~csr_wdata;
      default:   wval = rdata;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid) begin
      mepc_d            = trap_pc & ALIGN4;
      mcause_d          = '0;
      mcause_d[XLEN-1]  = trap_irq;
      mcause_d[3:0]     = trap_code;
      mtval_d           = trap_tval;
      mpie_d            = mie_q;
      mie_d             = 1'b0;
    end else if (mret_valid) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = wval[MSTATUS_MIE];
          mpie_d = wval[MSTATUS_MPIE];
        end
        CSR_MIE:      mtie_d     = wval[MIE_MTIE];
        // Only direct (00) and vectored (01) modes exist; 1x collapses to direct.
        CSR_MTVEC:    mtvec_d    = {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval & ALIGN4;
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  generate
    if (HAS_COUNTERS != 0) begin : g_cnt
      ysyx_23060077_csr_counter64 #(.XLEN(XLEN)) u_mcycle (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && (csr_addr == CSR_MCYCLE)),
        .wr_hi_i (csr_we && (csr_addr == CSR_MCYCLEH)),
        .wdata_i (wval),
        .rd_lo_o (cyc_lo),
        .rd_hi_o (cyc_hi)
      );
      ysyx_23060077_csr_counter64 #(.XLEN(XLEN)) u_minstret (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (instret_inc),
        .wr_lo_i (csr_we && (csr_addr == CSR_MINSTRET)),
        .wr_hi_i (csr_we && (csr_addr == CSR_MINSTRETH)),
        .wdata_i (wval),
        .rd_lo_o (ins_lo),
        .rd_hi_o (ins_hi)
      );
    end else begin : g_nocnt
      assign cyc_lo = '0;
      assign cyc_hi = '0;
      assign ins_lo = '0;
      assign ins_hi = '0;
    end
  endgenerate

  assign vec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign vec_off  = XLEN'({trap_code, 2'b00});

  always_comb begin
    if (!trap_valid)                               redirect_pc = mepc_q;
    else if (trap_irq && (mtvec_q[1:0] == 2'b01))  redirect_pc = vec_base + vec_off;
    else                                           redirect_pc = vec_base;
  end

  assign irq_pending = timer_irq && mtie_q && mie_q;
  assign csr_mstatus = mstatus_val;

endmodule

// File: tb/tb_ysyx_23060077_csr_file.sv
// Directed scoreboard bench for the CSR file: expectations are queued by the
// stimulus and popped/compared by a negedge monitor.
module tb_ysyx_23060077_csr_file;

  localparam int S_RDATA = 0;
  localparam int S_ILL   = 1;
  localparam int S_REDIR = 2;
  localparam int S_MST   = 3;
  localparam int S_IRQ   = 4;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic        trap_irq;
  logic [3:0]  trap_code;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        instret_inc;
  logic        timer_irq;
  logic        irq_pending;
  logic [31:0] redirect_pc;
  logic [31:0] csr_mstatus;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  ysyx_23060077_csr_file dut (
    .clock       (clock),
    .reset       (reset),
    .csr_valid   (csr_valid),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_valid  (trap_valid),
    .trap_irq    (trap_irq),
    .trap_code   (trap_code),
    .trap_pc     (trap_pc),
    .trap_tval   (trap_tval),
    .mret_valid  (mret_valid),
    .instret_inc (instret_inc),
    .timer_irq   (timer_irq),
    .irq_pending (irq_pending),
    .redirect_pc (redirect_pc),
    .csr_mstatus (csr_mstatus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_RDATA: act = csr_rdata;
        S_ILL:   act = {31'b0, csr_illegal};
        S_REDIR: act = redirect_pc;
        S_MST:   act = csr_mstatus;
        default: act = {31'b0, irq_pending};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v, input string n);
    exp_t x;
    x.sel = sel; x.val = v; x.name = n;
    sb.push_back(x);
  endtask

  task automatic idle();
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0;
    trap_valid = 1'b0; trap_irq = 1'b0; trap_code = '0;
    trap_pc = '0; trap_tval = '0; mret_valid = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
  endtask

  task automatic trap(input logic irq, input logic [3:0] code,
                      input logic [31:0] pc, input logic [31:0] tval);
    trap_valid = 1'b1; trap_irq = irq; trap_code = code; trap_pc = pc; trap_tval = tval;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; timer_irq = 1'b0; csr_addr = 12'hB00; idle();
    cyc();
    expect_val(S_RDATA, 32'h0, "rst_mcycle");
    expect_val(S_MST, 32'h1800, "rst_mstatus");
    expect_val(S_IRQ, 32'h0, "rst_irq");
    expect_val(S_REDIR, 32'h0, "rst_redirect");
    cyc();
    expect_val(S_RDATA, 32'h0, "rst_mcycle_held");
    cyc();
    reset = 1'b1;
    expect_val(S_MST, 32'h1800, "rel_mstatus");
    expect_val(S_RDATA, 32'h0, "rel_mcycle0");
    cyc(); expect_val(S_RDATA, 32'h1, "mcycle1");
    cyc(); expect_val(S_RDATA, 32'h2, "mcycle2");
    cyc(); expect_val(S_RDATA, 32'h3, "mcycle3");
    cyc(); csr_addr = 12'hF11;
    expect_val(S_RDATA, 32'h79737978, "mvendorid");
    expect_val(S_ILL, 32'h0, "mvendorid_legal");
    cyc(); csr_addr = 12'hF12;
    expect_val(S_RDATA, 32'h015FDE6D, "marchid");

    // mtvec vectored mode and interrupt redirect
    cyc(); csr(2'b01, 12'h305, 32'h80000101);
    expect_val(S_RDATA, 32'h0, "mtvec_old");
    cyc(); csr_addr = 12'h305;
    expect_val(S_RDATA, 32'h80000101, "mtvec_rd");
    trap(1'b1, 4'd7, 32'h80000013, 32'h12);
    expect_val(S_REDIR, 32'h8000011C, "redir_vec");
    cyc(); csr_addr = 12'h342;
    expect_val(S_RDATA, 32'h80000007, "mcause_irq");
    cyc(); csr_addr = 12'h341;
    expect_val(S_RDATA, 32'h80000010, "mepc_align");
    expect_val(S_REDIR, 32'h80000010, "redir_mepc");
    cyc(); csr_addr = 12'h343;
    expect_val(S_RDATA, 32'h12, "mtval");

    // ecall with MIE set, then mret
    cyc(); csr(2'b10, 12'h300, 32'h8);
    expect_val(S_RDATA, 32'h1800, "mstatus_old");
    cyc();
    expect_val(S_MST, 32'h1808, "mstatus_mie");
    trap(1'b0, 4'd11, 32'h80000046, 32'h0);
    expect_val(S_REDIR, 32'h80000100, "redir_exc");
    cyc(); csr_addr = 12'h341;
    expect_val(S_MST, 32'h1880, "mstatus_trap");
    expect_val(S_RDATA, 32'h80000044, "mepc_ecall");
    cyc(); csr_addr = 12'h342;
    expect_val(S_RDATA, 32'h0000000B, "mcause_ecall");
    mret_valid = 1'b1;
    expect_val(S_REDIR, 32'h80000044, "redir_mret");
    cyc();
    expect_val(S_MST, 32'h1888, "mstatus_mret");

    // trap beats a simultaneous CSR write
    csr(2'b01, 12'h340, 32'hDEADBEEF);
    trap(1'b0, 4'd2, 32'h80000200, 32'hBAD);
    expect_val(S_ILL, 32'h0, "mscratch_legal");
    cyc(); csr_addr = 12'h340;
    expect_val(S_RDATA, 32'h0, "mscratch_kept");
    expect_val(S_MST, 32'h1880, "mstatus_trap2");
    cyc(); csr_addr = 12'h342;
    expect_val(S_RDATA, 32'h2, "mcause_ill");
    cyc(); csr_addr = 12'h343;
    expect_val(S_RDATA, 32'hBAD, "mtval2");
    cyc(); csr(2'b01, 12'h340, 32'h5A5A0001);
    cyc(); csr_addr = 12'h340;
    expect_val(S_RDATA, 32'h5A5A0001, "mscratch_wr");
    // mret beats a simultaneous CSR write
    csr(2'b01, 12'h340, 32'h11);
    mret_valid = 1'b1;
    cyc(); csr_addr = 12'h340;
    expect_val(S_RDATA, 32'h5A5A0001, "mscratch_mret");
    expect_val(S_MST, 32'h1888, "mstatus_mret2");

    // legality
    cyc(); csr(2'b10, 12'hF11, 32'h5);
    expect_val(S_ILL, 32'h1, "ro_rs_nz");
    cyc(); csr(2'b10, 12'hF11, 32'h0);
    expect_val(S_ILL, 32'h0, "ro_rs_zero");
    expect_val(S_RDATA, 32'h79737978, "mvendorid_kept");
    cyc(); csr(2'b01, 12'hF12, 32'h0);
    expect_val(S_ILL, 32'h1, "ro_rw");
    cyc(); csr_addr = 12'h7C0;
    expect_val(S_ILL, 32'h1, "unmapped_ill");
    expect_val(S_RDATA, 32'h0, "unmapped_rd");
    cyc(); csr(2'b01, 12'h344, 32'hFFFFFFFF);
    expect_val(S_ILL, 32'h0, "mip_wr_legal");

    // mtvec mode 1x collapses to direct
    cyc(); csr(2'b01, 12'h305, 32'h00000402);
    cyc(); csr_addr = 12'h305;
    expect_val(S_RDATA, 32'h00000400, "mtvec_mode1x");
    trap(1'b1, 4'd7, 32'h80000300, 32'h0);
    expect_val(S_REDIR, 32'h00000400, "redir_direct_irq");
    cyc(); mret_valid = 1'b1;

    // counter wrap and write override
    cyc(); csr(2'b01, 12'hB00, 32'hFFFFFFFF);
    cyc(); csr(2'b01, 12'hB80, 32'hFFFFFFFF);
    expect_val(S_RDATA, 32'h0, "mcycleh_old");
    cyc(); csr_addr = 12'hB00;
    expect_val(S_RDATA, 32'hFFFFFFFF, "mcycle_max");
    cyc(); csr_addr = 12'hB00;
    expect_val(S_RDATA, 32'h0, "mcycle_wrap");
    cyc(); csr_addr = 12'hB80;
    expect_val(S_RDATA, 32'h0, "mcycleh_wrap");
    cyc(); csr_addr = 12'hB02; instret_inc = 1'b1;
    expect_val(S_RDATA, 32'h0, "minstret0");
    cyc(); instret_inc = 1'b1;
    cyc(); instret_inc = 1'b1;
    cyc(); csr_addr = 12'hB02;
    expect_val(S_RDATA, 32'h3, "minstret3");
    csr(2'b01, 12'hB02, 32'h100); instret_inc = 1'b1;
    cyc(); csr_addr = 12'hB02;
    expect_val(S_RDATA, 32'h100, "minstret_wr");
    cyc(); csr_addr = 12'hB82;
    expect_val(S_RDATA, 32'h0, "minstreth");

    // timer interrupt pending and asynchronous reset
    cyc(); csr(2'b01, 12'h304, 32'hFFFFFFFF);
    expect_val(S_IRQ, 32'h0, "irq_off");
    cyc(); csr_addr = 12'h304;
    expect_val(S_RDATA, 32'h80, "mie_mtie");
    expect_val(S_MST, 32'h1888, "mstatus_pre_irq");
    expect_val(S_IRQ, 32'h0, "irq_no_timer");
    cyc(); timer_irq = 1'b1; csr_addr = 12'h344;
    expect_val(S_RDATA, 32'h80, "mip_mtip");
    expect_val(S_IRQ, 32'h1, "irq_on");
    cyc(); reset = 1'b0; csr_addr = 12'h304;
    expect_val(S_RDATA, 32'h0, "arst_mie");
    expect_val(S_IRQ, 32'h0, "arst_irq");
    expect_val(S_MST, 32'h1800, "arst_mstatus");
    expect_val(S_REDIR, 32'h0, "arst_mepc");
    cyc(); csr_addr = 12'hB00;
    expect_val(S_RDATA, 32'h0, "arst_mcycle");
    cyc(); reset = 1'b1; csr_addr = 12'h304;
    expect_val(S_RDATA, 32'h0, "post_rst_mie");
    expect_val(S_IRQ, 32'h0, "post_rst_irq");

    cyc();
    @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_csr_file.md
Name: ysyx_23060077_csr_file

Overview:
Parametrised machine-mode CSR file with trap and interrupt support; successor to the fixed 32-bit ecall-only CSR block. Sits beside the EXU/WBU in the core:
- Serves Zicsr read/modify/write.
- Takes synchronous exceptions and timer interrupts with full mstatus MIE/MPIE stacking.
- Keeps 64-bit mcycle/minstret counters.
- Drives the trap/return redirect PC.

Parameters:
XLEN, 32, data width of every CSR and data port (32 or 64)
HAS_COUNTERS, 1, 1 = instantiate mcycle/minstret (and the *h halves when XLEN=32); 0 = those addresses are illegal
MVENDORID_VAL, 32'h79737978, constant returned by mvendorid
MARCHID_VAL, 32'h015FDE6D, constant returned by marchid

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low (asserted when 0)
csr_valid  in  1  CSR instruction commits this cycle
csr_op  in  2  01 RW, 10 RS, 11 RC; 00 = no write
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  rs1 value or zero-extended uimm
csr_rdata  out  XLEN  combinational old value of csr_addr
csr_illegal  out  1  combinational: unmapped address, or write to read-only (addr[11:10]==2'b11) with non-zero effect
trap_valid  in  1  take a trap this cycle
trap_irq  in  1  1 = interrupt, 0 = exception
trap_code  in  4  cause code (11 ecall, 2 illegal, 7 timer, ...)
trap_pc  in  XLEN  PC saved to mepc
trap_tval  in  XLEN  value for mtval
mret_valid  in  1  mret commits
instret_inc  in  1  one instruction retired
timer_irq  in  1  level machine-timer interrupt (CLINT)
irq_pending  out  1  mip.MTIP & mie.MTIE & mstatus.MIE
redirect_pc  out  XLEN  trap vector when trap_valid, else mepc
csr_mstatus  out  XLEN  current mstatus

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE[3] and MPIE[7] writable; MPP[12:11] hardwired 2'b11; all other bits read 0.
  - mie 0x304: only MTIE[7] writable.
  - mtvec 0x305: MODE[1:0] supports 00/01; 1x written is stored as 00.
  - mscratch 0x340; mepc 0x341 (bits[1:0] forced 0); mcause 0x342; mtval 0x343.
  - mip 0x344: MTIP[7] = timer_irq, read-only; writes to it are ignored, not illegal.
  - mcycle 0xB00 / minstret 0xB02, plus mcycleh 0xB80 / minstreth 0xB82 when XLEN=32.
  - mvendorid 0xF11, marchid 0xF12: constants.
- Read: csr_rdata is the pre-update value, combinational, zero for illegal addresses.
- Write: new = RW wdata | RS old|wdata | RC old&~wdata. Applied at the rising edge when csr_valid & ~csr_illegal & csr_op!=00.
  - RS/RC with wdata==0 to a read-only CSR is legal and causes no write.
- Update priority in one cycle: trap_valid > mret_valid > CSR write. A lower-priority event is dropped entirely.
- Trap (next edge):
  - mepc <= trap_pc & ~3.
  - mcause <= {trap_irq, zero-fill, trap_code}.
  - mtval <= trap_tval.
  - MPIE <= MIE, MIE <= 0.
- mret (next edge): MIE <= MPIE, MPIE <= 1.
- redirect_pc, combinational:
  - when trap_valid and mtvec.MODE==01 and trap_irq: {BASE,2'b00} + 4*trap_code;
  - otherwise when trap_valid: {BASE,2'b00};
  - when not trap_valid: mepc.
- Counters:
  - mcycle increments every cycle out of reset. minstret increments on instret_inc.
  - Both are 64-bit and wrap 2^64-1 -> 0.
  - A CSR write to any half of a counter in the same cycle overrides that counter's increment for that edge; the other half keeps its old value.
- Reset (async, reset==0): every register, including mepc, mtvec and the counters, is 0, so mstatus reads 0x1800. On release, mcycle reads 1 after the first edge. All outputs settle from the reset register values with no glitch sequencing required.
- Interrupt taking is decided by the core using irq_pending. This block never self-initiates a trap.

Decomposition:
- Package ysyx_23060077_csr_pkg holds:
  - CSR address localparams;
  - mstatus/mie/mip bit indices;
  - csr_op encodings;
  - cause codes (ECALL_M=11, ILLEGAL=2, MTI=7).
- One sub-module, ysyx_23060077_csr_counter64: 64-bit counter with inc, write-low, write-high, and XLEN-sliced read. It is instantiated twice.

Test Plan:
- Reset release, then csrr mstatus/mcycle -> 0x00001800, then 1,2,3 on consecutive cycles; mvendorid reads 0x79737978.
- csrrw mtvec 0x80000101 -> reads 0x80000101; trap_valid, trap_irq=1, code=7 -> redirect_pc 0x8000011C; mcause 0x80000007.
- MIE=1, ecall trap at pc 0x80000046 -> mepc 0x80000044, mstatus 0x1880; then mret -> mstatus 0x1888, redirect_pc 0x80000044.
- csr_valid RW mscratch with simultaneous trap_valid -> mscratch unchanged, trap state updated; csrrs mvendorid wdata=5 -> csr_illegal=1, no change.
- Write mcycle = 0xFFFFFFFF, mcycleh = 0xFFFFFFFF -> after 2 cycles mcycle/mcycleh = 0x00000000/0x00000000 (wrap); minstret write during instret_inc -> written value kept.
- mie.MTIE=1, MIE=1, timer_irq=1 -> irq_pending=1; assert reset mid-run -> all CSRs 0 immediately, irq_pending=0.
